cv32e40p_irq_gen: RTL and testbench

CV32E40P_IRQ_GEN -- requirements
Module: cv32e40p_irq_gen

---
 rtl/cv32e40p_pkg.sv | 29 ++
 rtl/cv32e40p_irq_gen_if.sv | 15 +
 rtl/cv32e40p_irq_sync.sv | 21 ++
 rtl/cv32e40p_irq_gen.sv | 113 +++++++++++
 tb/tb_cv32e40p_irq_gen.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared constants for the interrupt generator: CSR interrupt bit positions,
// register offsets and the access payload.
package cv32e40p_pkg;

  localparam int unsigned CSR_MSIX_BIT = 3;
  localparam int unsigned CSR_MTIX_BIT = 7;
  localparam int unsigned CSR_MEIX_BIT = 11;

  localparam int unsigned IRQ_FAST_LSB = 16;
  localparam int unsigned IRQ_FAST_NUM = 16;
  localparam int unsigned IRQ_ADDR_W   = 6;
  localparam int unsigned IRQ_DATA_W   = 32;

  localparam logic [IRQ_ADDR_W-1:0] IRQ_OFF_MSIP      = 6'h00;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_OFF_MTIME_LO  = 6'h08;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_OFF_MTIME_HI  = 6'h0C;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_OFF_MTCMP_LO  = 6'h10;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_OFF_MTCMP_HI  = 6'h14;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_OFF_FAST_PEND = 6'h18;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_OFF_FAST_EN   = 6'h1C;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_OFF_FAST_SET  = 6'h20;

  typedef struct packed {
    logic                  we;
    logic [IRQ_ADDR_W-1:0] addr;
    logic [IRQ_DATA_W-1:0] wdata;
  } irq_req_t;

endpackage

// File: rtl/cv32e40p_irq_gen_if.sv
// Register access bus of the interrupt generator.
interface cv32e40p_irq_gen_if;
  import cv32e40p_pkg::*;

  logic                  req_i;
  logic                  we_i;
  logic [IRQ_ADDR_W-1:0] addr_i;
  logic [IRQ_DATA_W-1:0] wdata_i;
  logic                  gnt_o;
  logic                  rvalid_o;
  logic [IRQ_DATA_W-1:0] rdata_o;

  modport master (output req_i, we_i, addr_i, wdata_i, input gnt_o, rvalid_o, rdata_o);
  modport slave  (input req_i, we_i, addr_i, wdata_i, output gnt_o, rvalid_o, rdata_o);
endinterface

// File: rtl/cv32e40p_irq_sync.sv
// Multi-flop synchronizer for a vector of asynchronous inputs.
module cv32e40p_irq_sync #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage <= '0;
    else        stage <= {stage[DEPTH-2:0], d};
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/cv32e40p_irq_gen.sv
// Machine timer, software and fast interrupt generator with a small register
// port; drives the core's 32-bit irq_i vector.
module cv32e40p_irq_gen
  import cv32e40p_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick_i,
  input  logic                    ext_irq_i,
  input  logic [IRQ_FAST_NUM-1:0] fast_irq_i,
  cv32e40p_irq_gen_if.slave       bus,
  output logic [31:0]             irq_o
);

  irq_req_t                acc;
  logic                    wr, rd;
  logic                    unused_addr_lsb;
  logic [IRQ_DATA_W-1:0]   rd_data, rdata;
  logic                    rvalid;
  logic [63:0]             mtime, mtimecmp;
  logic                    mti, msip;
  logic                    ext_sync;
  logic [IRQ_FAST_NUM-1:0] fast_sync, fast_prev, fast_pend, fast_en;
  logic [IRQ_FAST_NUM-1:0] fast_set, fast_clr;

  assign acc = '{we: bus.we_i, addr: {bus.addr_i[5:2], 2'b00}, wdata: bus.wdata_i};
  assign unused_addr_lsb = ^bus.addr_i[1:0];
  assign wr = bus.req_i & acc.we;
  assign rd = bus.req_i & ~acc.we;

  assign bus.gnt_o    = bus.req_i;
  assign bus.rvalid_o = rvalid;
  assign bus.rdata_o  = rdata;

  cv32e40p_irq_sync #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_ext_sync (
    .clk(clk), .rst_n(rst_n), .d(ext_irq_i), .q(ext_sync)
  );

  cv32e40p_irq_sync #(.WIDTH(IRQ_FAST_NUM), .DEPTH(SYNC_STAGES)) u_fast_sync (
    .clk(clk), .rst_n(rst_n), .d(fast_irq_i), .q(fast_sync)
  );

  always_comb begin
    rd_data = '0;
    case (acc.addr)
      IRQ_OFF_MSIP:      rd_data = {31'd0, msip};
      IRQ_OFF_MTIME_LO:  rd_data = mtime[31:0];
      IRQ_OFF_MTIME_HI:  rd_data = mtime[63:32];
      IRQ_OFF_MTCMP_LO:  rd_data = mtimecmp[31:0];
      IRQ_OFF_MTCMP_HI:  rd_data = mtimecmp[63:32];
      IRQ_OFF_FAST_PEND: rd_data = {fast_pend, 16'd0};
      IRQ_OFF_FAST_EN:   rd_data = {fast_en, 16'd0};
      default:           rd_data = '0;
    endcase
  end

  // Response one cycle after acceptance; writes and idle cycles return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= bus.req_i;
      rdata  <= rd ? rd_data : '0;
    end
  end

  // A register write to either mtime half suppresses that cycle's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime    <= '0;
      mtimecmp <= '1;
      mti      <= 1'b0;
      msip     <= 1'b0;
    end else begin
      if (wr && acc.addr == IRQ_OFF_MTIME_LO)      mtime[31:0]  <= acc.wdata;
      else if (wr && acc.addr == IRQ_OFF_MTIME_HI) mtime[63:32] <= acc.wdata;
      else if (tick_i)                             mtime        <= mtime + 64'd1;
      if (wr && acc.addr == IRQ_OFF_MTCMP_LO) mtimecmp[31:0]  <= acc.wdata;
      if (wr && acc.addr == IRQ_OFF_MTCMP_HI) mtimecmp[63:32] <= acc.wdata;
      if (wr && acc.addr == IRQ_OFF_MSIP)     msip            <= acc.wdata[0];
      mti <= (mtime >= mtimecmp);
    end
  end

  // Set (edge or FAST_SET) takes precedence over a same-cycle W1C.
  assign fast_set = (fast_sync & ~fast_prev & fast_en)
                  | ((wr && acc.addr == IRQ_OFF_FAST_SET) ? acc.wdata[31:16] : '0);
  assign fast_clr = (wr && acc.addr == IRQ_OFF_FAST_PEND) ? acc.wdata[31:16] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fast_prev <= '0;
      fast_pend <= '0;
      fast_en   <= '0;
    end else begin
      fast_prev <= fast_sync;
      fast_pend <= (fast_pend & ~fast_clr) | fast_set;
      if (wr && acc.addr == IRQ_OFF_FAST_EN) fast_en <= acc.wdata[31:16];
    end
  end

  always_comb begin
    irq_o                                  = '0;
    irq_o[CSR_MSIX_BIT]                    = msip;
    irq_o[CSR_MTIX_BIT]                    = mti;
    irq_o[CSR_MEIX_BIT]                    = ext_sync;
    irq_o[IRQ_FAST_LSB +: IRQ_FAST_NUM]    = fast_pend;
  end

endmodule

// File: tb/tb_cv32e40p_irq_gen.sv
// Directed bench for cv32e40p_irq_gen; read responses are checked against a
// scoreboard of expected data queued when each access is issued.
module tb_cv32e40p_irq_gen;
  import cv32e40p_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        ext_irq;
  logic [15:0] fast_irq;
  logic [31:0] irq;

  cv32e40p_irq_gen_if bus ();

  cv32e40p_irq_gen #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .tick_i(tick), .ext_irq_i(ext_irq),
    .fast_irq_i(fast_irq), .bus(bus), .irq_o(irq)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [63:0] m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access: request for a cycle, then check the response next cycle.
  task automatic access(input logic we, input logic [5:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input string tag);
    logic [31:0] e;
    bus.req_i   = 1'b1;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.wdata_i = wdata;
    chk({tag, " gnt"}, 64'(bus.gnt_o), 64'd1);
    sb.push_back(we ? 32'h0 : exp_rdata);
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;
    chk({tag, " rvalid"}, 64'(bus.rvalid_o), 64'd1);
    e = sb.pop_front();
    chk({tag, " rdata"}, 64'(bus.rdata_o), 64'(e));
  endtask

  task automatic wr(input logic [5:0] addr, input logic [31:0] data, input string tag);
    access(1'b1, addr, data, 32'h0, tag);
  endtask

  task automatic rd(input logic [5:0] addr, input logic [31:0] exp, input string tag);
    access(1'b0, addr, 32'h0, exp, tag);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; ext_irq = 1'b0; fast_irq = '0;
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset irq", 64'(irq), 64'd0);
    chk("reset rvalid", 64'(bus.rvalid_o), 64'd0);
    chk("reset rdata", 64'(bus.rdata_o), 64'd0);
    rst_n = 1'b1;
    cyc();
    chk("idle rvalid", 64'(bus.rvalid_o), 64'd0);

    rd(IRQ_OFF_MTCMP_LO, 32'hFFFF_FFFF, "cmp lo rst");
    rd(IRQ_OFF_MTCMP_HI, 32'hFFFF_FFFF, "cmp hi rst");
    rd(IRQ_OFF_MTIME_LO, 32'h0, "mtime lo rst");

    // Software interrupt and unmapped / write-only reads
    wr(IRQ_OFF_MSIP, 32'h1, "msip set");
    chk("msip irq", 64'(irq), 64'h8);
    rd(IRQ_OFF_MSIP, 32'h1, "msip rd");
    wr(IRQ_OFF_MSIP, 32'h0, "msip clr");
    chk("msip irq clr", 64'(irq), 64'h0);
    rd(6'h3C, 32'h0, "unmapped");
    rd(IRQ_OFF_FAST_SET, 32'h0, "fast_set rd");
    rd(6'h0B, 32'h0, "mtime lo lsb ignored");
    chk("rdata idle zero", 64'(bus.rdata_o), 64'd0);

    // Timer compare: irq[7] follows previous-cycle mtime >= mtimecmp
    wr(IRQ_OFF_MTCMP_HI, 32'h0, "cmp hi");
    wr(IRQ_OFF_MTCMP_LO, 32'h5, "cmp lo");
    wr(IRQ_OFF_MTIME_LO, 32'h0, "mtime lo");
    wr(IRQ_OFF_MTIME_HI, 32'h0, "mtime hi");
    m = 64'd0;
    tick = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic exp_mti;
      @(posedge clk);
      exp_mti = (m >= 64'd5);
      m = m + 64'd1;
      #1;
      chk($sformatf("mti step %0d", i), 64'(irq[7]), 64'(exp_mti));
    end
    tick = 1'b0;
    rd(IRQ_OFF_MTIME_LO, m[31:0], "mtime count");
    wr(IRQ_OFF_MTCMP_LO, 32'hFFFF_FFFF, "cmp lo max");
    chk("mti lag", 64'(irq[7]), 64'd1);
    cyc();
    chk("mti fall", 64'(irq[7]), 64'd0);

    // 64-bit wrap
    wr(IRQ_OFF_MTIME_HI, 32'hFFFF_FFFF, "wrap hi");
    wr(IRQ_OFF_MTIME_LO, 32'hFFFF_FFFE, "wrap lo");
    tick = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tick = 1'b0;
    rd(IRQ_OFF_MTIME_HI, 32'h0, "wrap rd hi");
    rd(IRQ_OFF_MTIME_LO, 32'h1, "wrap rd lo");

    // Write beats a same-cycle tick; other half holds
    tick = 1'b1;
    wr(IRQ_OFF_MTIME_LO, 32'h100, "mtime wr prio");
    tick = 1'b0;
    rd(IRQ_OFF_MTIME_LO, 32'h100, "prio lo");
    rd(IRQ_OFF_MTIME_HI, 32'h0, "prio hi");

    // Fast interrupt edge path: set on the third edge after the rise
    wr(IRQ_OFF_FAST_EN, 32'h0001_0000, "fen 16");
    fast_irq[0] = 1'b1;
    cyc(); chk("fast edge1", 64'(irq[16]), 64'd0);
    cyc(); chk("fast edge2", 64'(irq[16]), 64'd0);
    cyc(); chk("fast edge3", 64'(irq[16]), 64'd1);
    fast_irq[0] = 1'b0;
    wr(IRQ_OFF_FAST_PEND, 32'h0001_0000, "fpend w1c");
    chk("fast cleared", 64'(irq[16]), 64'd0);
    wr(IRQ_OFF_FAST_EN, 32'h0, "fen off");
    fast_irq[0] = 1'b1;
    repeat (4) cyc();
    fast_irq[0] = 1'b0;
    repeat (3) cyc();
    chk("fast disabled", 64'(irq), 64'd0);

    // Edge and W1C on bit 17 in the same cycle: set wins
    wr(IRQ_OFF_FAST_EN, 32'h0002_0000, "fen 17");
    fast_irq[1] = 1'b1;
    cyc();
    cyc();
    wr(IRQ_OFF_FAST_PEND, 32'h0002_0000, "w1c race");
    chk("race set wins", 64'(irq[17]), 64'd1);
    rd(IRQ_OFF_FAST_PEND, 32'h0002_0000, "race pend rd");
    wr(IRQ_OFF_FAST_PEND, 32'h0002_0000, "w1c 17");
    chk("w1c 17 irq", 64'(irq[31:16]), 64'd0);

    // FAST_SET ignores FAST_EN; clearing FAST_EN keeps pending
    wr(IRQ_OFF_FAST_SET, 32'h8000_0000, "fset 31");
    chk("fset irq", 64'(irq[31:16]), 64'h8000);
    wr(IRQ_OFF_FAST_EN, 32'h0, "fen clr");
    chk("pend kept", 64'(irq[31:16]), 64'h8000);
    rd(IRQ_OFF_FAST_EN, 32'h0, "fen rd");

    // External level interrupt through the synchronizer
    ext_irq = 1'b1;
    cyc(); chk("ext sync1", 64'(irq[11]), 64'd0);
    cyc(); chk("ext sync2", 64'(irq[11]), 64'd1);

    // Reset in the middle of a read with mtime counting
    wr(IRQ_OFF_MSIP, 32'h1, "msip pre rst");
    tick = 1'b1;
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = IRQ_OFF_MTIME_LO;
    sb.push_back(32'h0);
    #3;
    rst_n = 1'b0;
    #1;
    bus.req_i = 1'b0;
    tick = 1'b0;
    ext_irq = 1'b0;
    fast_irq = '0;
    sb.delete();
    chk("rst irq", 64'(irq), 64'd0);
    chk("rst rvalid", 64'(bus.rvalid_o), 64'd0);
    chk("rst rdata", 64'(bus.rdata_o), 64'd0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("post rst rvalid %0d", i), 64'(bus.rvalid_o), 64'd0);
    end
    chk("post rst irq", 64'(irq), 64'd0);
    rd(IRQ_OFF_MTCMP_LO, 32'hFFFF_FFFF, "post rst cmp lo");
    rd(IRQ_OFF_MTIME_LO, 32'h0, "post rst mtime");
    rd(IRQ_OFF_FAST_PEND, 32'h0, "post rst pend");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
